// File: rtl/lpc_sniffer_pkg.sv
// Shared constants and state encodings for the LPC/TPM sniffer datapath.
// DW (RECORD_DW) is common to the decoder, the ringbuffer and the UART drain.
package lpc_sniffer_pkg;

  localparam int         RECORD_DW            = 48;
  localparam int         DEFAULT_CLKS_PER_BIT = 104;  // 12 MHz / 115200 baud
  localparam logic [7:0] DEFAULT_TERM         = 8'h0A;

  typedef enum logic [1:0] {
    DRAIN_IDLE,
    DRAIN_POP,
    DRAIN_LOAD,
    DRAIN_SEND
  } drain_state_t;

  typedef enum logic [1:0] {
    BIT_IDLE,
    BIT_START,
    BIT_DATA,
    BIT_STOP
  } bit_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser. A start request during the last stop-bit cycle chains
// straight into the next start bit, so consecutive bytes have no idle gap.
module uart_tx_byte
  import lpc_sniffer_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  bit_state_t    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          bit_end;

  assign bit_end = (cnt_reg == CNT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= BIT_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    done       = 1'b0;
    case (state_reg)
      BIT_IDLE: begin
        if (start) begin
          state_next = BIT_START;
          cnt_next   = '0;
          shift_next = data;
        end
      end
      BIT_START: begin
        if (bit_end) begin
          state_next = BIT_DATA;
          cnt_next   = '0;
          bit_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      BIT_DATA: begin
        if (bit_end) begin
          cnt_next   = '0;
          shift_next = {1'b0, shift_reg[7:1]};
          if (bit_reg == 3'd7) begin
            state_next = BIT_STOP;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      BIT_STOP: begin
        if (bit_end) begin
          done     = 1'b1;
          cnt_next = '0;
          if (start) begin
            state_next = BIT_START;
            shift_next = data;
          end else begin
            state_next = BIT_IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = BIT_IDLE;
    endcase
  end

  always_comb begin
    case (state_reg)
      BIT_START: tx = 1'b0;
      BIT_DATA:  tx = shift_reg[0];
      default:   tx = 1'b1;
    endcase
  end

endmodule

// File: rtl/ringbuffer_uart_drain.sv
// Pops one record at a time from the sniffer ringbuffer and streams it over
// UART as DW/8 bytes (MSB byte first) followed by a terminator byte.
module ringbuffer_uart_drain
  import lpc_sniffer_pkg::*;
#(
  parameter int         DW           = RECORD_DW,
  parameter int         CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter logic [7:0] TERM         = DEFAULT_TERM
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          empty,
  input  logic          overflow,
  input  logic [DW-1:0] read_data,
  output logic          read_clock_enable,
  output logic          tx,
  output logic          busy,
  output logic          overflow_seen
);

  localparam int NB = DW / 8;
  localparam int IW = $clog2(NB + 1);

  if (DW % 8 != 0 || DW < 8 || CLKS_PER_BIT < 2) begin : g_param_check
    $error("ringbuffer_uart_drain: DW must be a non-zero multiple of 8 and CLKS_PER_BIT >= 2");
  end

  drain_state_t  state_reg, state_next;
  logic [DW-1:0] record_reg, record_next;
  logic [IW-1:0] index_reg, index_next;
  logic          overflow_seen_reg;
  logic [7:0]    frame_bytes [NB+1];
  logic          byte_start;
  logic [7:0]    byte_data;
  logic          byte_done;

  // Frame byte table: record bytes MSB-first, terminator in the last slot.
  genvar gi;
  for (gi = 0; gi < NB; gi++) begin : g_frame_bytes
    assign frame_bytes[gi] = record_reg[DW-1-8*gi -: 8];
  end
  assign frame_bytes[NB] = TERM;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg         <= DRAIN_IDLE;
      record_reg        <= '0;
      index_reg         <= '0;
      overflow_seen_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      record_reg <= record_next;
      index_reg  <= index_next;
      if (overflow) begin
        overflow_seen_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    record_next = record_reg;
    index_next  = index_reg;
    byte_start  = 1'b0;
    byte_data   = '0;
    case (state_reg)
      DRAIN_IDLE: begin
        if (!empty) begin
          state_next = DRAIN_POP;
        end
      end
      DRAIN_POP: state_next = DRAIN_LOAD;
      DRAIN_LOAD: begin
        // The first byte comes straight from read_data so tx falls this edge.
        record_next = read_data;
        index_next  = '0;
        byte_start  = 1'b1;
        byte_data   = read_data[DW-1 -: 8];
        state_next  = DRAIN_SEND;
      end
      DRAIN_SEND: begin
        if (byte_done) begin
          if (index_reg < IW'(NB)) begin
            index_next = index_reg + 1'b1;
            byte_start = 1'b1;
            byte_data  = frame_bytes[index_next];
          end else begin
            state_next = DRAIN_IDLE;
          end
        end
      end
      default: state_next = DRAIN_IDLE;
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clock(clock),
    .reset(reset),
    .start(byte_start),
    .data (byte_data),
    .tx   (tx),
    .done (byte_done)
  );

  assign read_clock_enable = (state_reg == DRAIN_POP);
  assign busy              = (state_reg != DRAIN_IDLE);
  assign overflow_seen     = overflow_seen_reg;

endmodule

// File: tb/tb_ringbuffer_uart_drain.sv
// Randomised bench for ringbuffer_uart_drain: a queue-based ringbuffer model,
// a bit-level UART receiver and frame timing derived from baud arithmetic.
module tb_ringbuffer_uart_drain;

  localparam int         DW       = 16;
  localparam int         CPB      = 4;
  localparam logic [7:0] TERM     = 8'h0A;
  localparam int         NB       = DW / 8;
  localparam int         BYTE_CYC = 10 * CPB;
  localparam int         FRAME    = (NB + 1) * BYTE_CYC;
  localparam int         GAP      = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          empty;
  logic          overflow;
  logic [DW-1:0] read_data;
  logic          read_clock_enable;
  logic          tx;
  logic          busy;
  logic          overflow_seen;

  ringbuffer_uart_drain #(
    .DW(DW),
    .CLKS_PER_BIT(CPB),
    .TERM(TERM)
  ) dut (
    .clock(clock),
    .reset(reset),
    .empty(empty),
    .overflow(overflow),
    .read_data(read_data),
    .read_clock_enable(read_clock_enable),
    .tx(tx),
    .busy(busy),
    .overflow_seen(overflow_seen)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Ringbuffer model and pop monitor.
  logic [DW-1:0] rb[$];
  int            pop_t[$];
  always @(negedge clock) begin
    if (read_clock_enable) begin
      pop_t.push_back(cyc);
      if (rb.size() > 0) read_data = rb.pop_front();
      empty = (rb.size() == 0);
    end
  end

  // UART receiver: samples every cycle of a byte to verify exact bit widths.
  logic [7:0] rx_b[$];
  int         rx_t[$];
  logic       rx_ok[$];
  initial begin
    logic [39:0] s;
    logic [7:0]  b;
    logic        ok;
    int          t0;
    forever begin
      @(negedge clock);
      if (tx === 1'b0) begin
        t0   = cyc;
        s    = '0;
        for (int o = 1; o < 40; o++) begin
          @(negedge clock);
          s[o] = tx;
        end
        ok = (s[0] == 1'b0) && (s[36] == 1'b1);
        for (int j = 0; j < 10; j++)
          for (int m = 1; m < CPB; m++)
            if (s[CPB*j+m] !== s[CPB*j]) ok = 1'b0;
        for (int j = 0; j < 8; j++) b[j] = s[CPB*(j+1)];
        rx_b.push_back(b);
        rx_t.push_back(t0);
        rx_ok.push_back(ok);
      end
    end
  end

  logic [DW-1:0] burst_recs[4];

  task automatic flush();
    rx_b.delete();
    rx_t.delete();
    rx_ok.delete();
    pop_t.delete();
  endtask

  // k = cycle count at the negedge where the DUT first sees empty=0 ahead.
  task automatic expect_frames(input int k, input int n);
    int            s0;
    int            last;
    int            idx;
    logic [DW-1:0] rec;
    logic [7:0]    eb;
    s0   = k + 3;
    last = s0 + (n - 1) * (FRAME + GAP);
    while (cyc < last + FRAME - 1) @(negedge clock);
    check("busy_end_hi", busy, 1);
    @(negedge clock);
    check("busy_end_lo", busy, 0);
    check("n_pops", pop_t.size(), n);
    check("n_bytes", rx_b.size(), n * (NB + 1));
    for (int f = 0; f < n; f++) begin
      rec = burst_recs[f];
      $display("frame %0d record %h start_cycle %0d", f, rec, s0 + f * (FRAME + GAP));
      if (f < pop_t.size()) check("pop_time", pop_t[f], s0 + f * (FRAME + GAP) - 2);
      for (int b = 0; b <= NB; b++) begin
        idx = f * (NB + 1) + b;
        eb  = (b == NB) ? TERM : 8'(rec >> (8 * (NB - 1 - b)));
        if (idx < rx_b.size()) begin
          check("byte_val", rx_b[idx], eb);
          check("byte_time", rx_t[idx], s0 + f * (FRAME + GAP) + b * BYTE_CYC);
          check("byte_bits", rx_ok[idx], 1);
        end
      end
    end
  endtask

  task automatic run_burst(input int n);
    int k;
    k = cyc;
    flush();
    for (int i = 0; i < n; i++) rb.push_back(burst_recs[i]);
    empty = 1'b0;
    expect_frames(k, n);
  endtask

  initial begin
    int k;
    int n;
    int cnt_rce;
    int cnt_low;
    int cnt_busy;
    logic [DW-1:0] rec_a;
    logic [DW-1:0] rec_b;

    reset     = 1'b1;
    empty     = 1'b1;
    overflow  = 1'b0;
    read_data = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_rce", read_clock_enable, 0);
    check("rst_ovf", overflow_seen, 0);
    cnt_rce = 0; cnt_low = 0; cnt_busy = 0;
    repeat (20) begin
      @(negedge clock);
      if (read_clock_enable) cnt_rce++;
      if (!tx) cnt_low++;
      if (busy) cnt_busy++;
    end
    check("idle_rce", cnt_rce, 0);
    check("idle_tx_low", cnt_low, 0);
    check("idle_busy", cnt_busy, 0);
    check("idle_ovf", overflow_seen, 0);

    burst_recs[0] = 16'hA55A;
    run_burst(1);

    burst_recs[0] = 16'h1234;
    burst_recs[1] = 16'hBEEF;
    run_burst(2);

    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) burst_recs[i] = DW'($urandom);
      run_burst(n);
    end

    // Reset mid-frame: the popped record is lost, the next one goes out whole.
    rec_a = DW'($urandom);
    rec_b = DW'($urandom);
    k = cyc;
    flush();
    rb.push_back(rec_a);
    rb.push_back(rec_b);
    empty = 1'b0;
    while (cyc < k + 50) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    repeat (44) @(negedge clock);
    flush();
    burst_recs[0] = rec_b;
    k = cyc;
    reset = 1'b0;
    expect_frames(k, 1);
    check("midrst_rb_left", rb.size(), 0);

    // One-cycle overflow pulse mid-frame.
    burst_recs[0] = DW'($urandom);
    k = cyc;
    flush();
    rb.push_back(burst_recs[0]);
    empty = 1'b0;
    while (cyc < k + 30) @(negedge clock);
    overflow = 1'b1;
    @(negedge clock);
    overflow = 1'b0;
    check("ovf_set", overflow_seen, 1);
    expect_frames(k, 1);
    check("ovf_hold", overflow_seen, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("ovf_clr", overflow_seen, 0);

    // Buffer drained: the line must stay idle with no further pops.
    flush();
    cnt_low = 0;
    repeat (200) begin
      @(negedge clock);
      if (tx !== 1'b1) cnt_low++;
    end
    check("drained_pops", pop_t.size(), 0);
    check("drained_tx_low", cnt_low, 0);
    check("drained_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
